alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  in  1  rising-edge clock, the only clock.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 instr  in  16  current instruction register contents: opcode [15:12], rs [11:9], rt [8:6], rd [5:3], imm/jump target [7:0].
REQ-004 mem_ready  in  1  memory handshake: the pending read or write completes in the cycle this is high.
REQ-005 alu_zero  in  1  zero flag from the ALU.
REQ-006 alu_control  out  3  ALU op code: 000 MOV, 001 ADD, 010 AND, 011 NOT, 100 NOR, 110 SLL, 111 SRL; 101 is never driven.
REQ-007 alu_src_a  out  1  ALU A operand select: 0 = PC, 1 = rs.
REQ-008 alu_src_b  out  2  ALU B operand select: 00 = rt, 01 = imm, 10 = constant 1.
REQ-009 mem_read  out  1  memory read request.
REQ-010 mem_write  out  1  memory write request.
REQ-011 mem_addr_sel  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 ir_write  out  1  load instruction register.
REQ-013 pc_write  out  1  load PC.
REQ-014 pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = imm.
REQ-015 reg_write  out  1  register-file write enable.
REQ-016 wb_sel  out  2  writeback source: 00 = ALUOut to rd, 01 = ALUOut to rt, 10 = memory data to rt.
REQ-017 halted  out  1  high while in HALT.
REQ-018 illegal  out  1  one-cycle pulse on an illegal opcode.

Function
REQ-019 Opcodes: 0x0-0x4, 0x6, 0x7 = R-type, alu_control = opcode[2:0]; 0x8 ADDI; 0x9 LW; 0xA SW; 0xB BZ (branch if rs == 0); 0xC J; 0xF HALT; 0x5, 0xD, 0xE illegal.
REQ-020 States: FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT; 4-bit encoding.
REQ-021 Every output not listed for a state is 0 in that state; all outputs are combinational from state, instr, mem_ready and alu_zero (Moore, except where gating is stated).
REQ-022 FETCH: mem_read=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=10, alu_control=001.
REQ-023 FETCH: ir_write=pc_write=mem_ready; on mem_ready go to DECODE, otherwise hold.
REQ-024 DECODE: alu_src_a=0, alu_src_b=01, alu_control=001 (branch target to ALUOut); next state by opcode: R-type->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BZ->BRANCH, J->JUMP, HALT->HALT, illegal->FETCH with illegal=1 for this cycle.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=00, alu_control=opcode[2:0]; next WB_R.
REQ-026 WB_R: reg_write=1, wb_sel=00, alu_control held at opcode[2:0]; next FETCH.
REQ-027 EXEC_I: alu_src_a=1, alu_src_b=01, alu_control=001; next WB_I; WB_I: reg_write=1, wb_sel=01; next FETCH.
REQ-028 MEM_ADDR: alu_src_a=1, alu_src_b=01, alu_control=001; next MEM_RD for LW, MEM_WR for SW.
REQ-029 MEM_RD: mem_read=1, mem_addr_sel=1; hold until mem_ready, then WB_MEM; WB_MEM: reg_write=1, wb_sel=10; next FETCH.
REQ-030 MEM_WR: mem_write=1, mem_addr_sel=1; hold until mem_ready, then FETCH.
REQ-031 BRANCH: alu_src_a=1, alu_control=000, pc_src=01, pc_write=alu_zero; next FETCH.
REQ-032 JUMP: pc_write=1, pc_src=10; next FETCH.
REQ-033 HALT: halted=1, all strobes 0; remains in HALT until reset.
REQ-034 mem_read and mem_write are never both 1; mem_read or mem_write stays high continuously for an unbounded stall.
REQ-035 Latency in cycles, with mem_ready always 1: R-type 4, ADDI 4, LW 5, SW 4, BZ 3, J 3.

Reset
REQ-036 reset high at a rising edge: the next state is FETCH regardless of the current state, including mid-stall in MEM_RD or MEM_WR.
REQ-037 While reset is high, mem_read, mem_write, ir_write, pc_write, reg_write and illegal are forced to 0, and halted is 0.

Structure
REQ-038 Package mips8_pkg holds the opcode constants, the ALU control codes, the state enum, and the alu_src_b, pc_src and wb_sel encodings.
REQ-039 Opcode classification (R-type/I/mem/branch/jump/halt/illegal) lives in a combinational sub-module, ctrl_decode; alu_sequencer holds the state register and output logic.

Verification
REQ-040 Reset mid-MEM_RD with mem_ready=0 -> FETCH on the next cycle, no reg_write, mem_read=0 while reset is high.
REQ-041 instr=0x1xxx (ADD), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R, with alu_control=001 in EXEC_R and reg_write=1, wb_sel=00 in WB_R.
REQ-042 LW with mem_ready low 3 cycles in MEM_RD -> mem_read held 3 cycles, mem_addr_sel=1, then WB_MEM with wb_sel=10.
REQ-043 BZ with alu_zero=1, then again with alu_zero=0 -> pc_write=1 and pc_src=01 in the first case, pc_write=0 in the second.
REQ-044 instr=0x5xxx -> illegal=1 for one cycle in DECODE, then FETCH, with alu_control never equal to 101.
REQ-045 instr=0xFxxx -> halted=1 held for 20 cycles with no strobes; reset returns the block to FETCH.

Source files
------------

// File: rtl/mips8_pkg.sv
// Shared encodings for the multi-cycle MIPS-8 control path: opcodes, ALU codes,
// sequencer states and the operand/PC/writeback select encodings.
package mips8_pkg;

    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_J    = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] SRC_B_RT  = 2'b00;
    localparam logic [1:0] SRC_B_IMM = 2'b01;
    localparam logic [1:0] SRC_B_ONE = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_IMM    = 2'b10;

    localparam logic [1:0] WB_ALU_RD = 2'b00;
    localparam logic [1:0] WB_ALU_RT = 2'b01;
    localparam logic [1:0] WB_MEM_RT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_MEM, CLS_BR, CLS_JMP, CLS_HALT, CLS_ILL
    } op_class_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction/handshake inputs and control strobes between the sequencer (master)
// and the datapath it steers (slave).
interface alu_sequencer_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [2:0]  alu_control;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        illegal;

    modport master (
        input  instr, mem_ready, alu_zero,
        output alu_control, alu_src_a, alu_src_b, mem_read, mem_write, mem_addr_sel,
               ir_write, pc_write, pc_src, reg_write, wb_sel, halted, illegal
    );
    modport slave (
        output instr, mem_ready, alu_zero,
        input  alu_control, alu_src_a, alu_src_b, mem_read, mem_write, mem_addr_sel,
               ir_write, pc_write, pc_src, reg_write, wb_sel, halted, illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; also flags stores so MEM_ADDR can pick read vs write.
module ctrl_decode
    import mips8_pkg::*;
(
    input  logic [3:0] opcode_i,
    output op_class_e  cls_o,
    output logic       is_store_o
);
    always_comb begin
        cls_o      = CLS_ILL;
        is_store_o = (opcode_i == OP_SW);
        unique case (opcode_i)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7: cls_o = CLS_R;
            OP_ADDI:                                  cls_o = CLS_I;
            OP_LW, OP_SW:                             cls_o = CLS_MEM;
            OP_BZ:                                    cls_o = CLS_BR;
            OP_J:                                     cls_o = CLS_JMP;
            OP_HALT:                                  cls_o = CLS_HALT;
            default:                                  cls_o = CLS_ILL;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM: state register plus Moore outputs, with mem_ready and
// alu_zero gating only the FETCH load strobes and the branch PC write.
module alu_sequencer
    import mips8_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.master bus
);
    state_e    state_q, state_d;
    op_class_e cls;
    logic      is_store;
    logic [2:0] op_alu;
    logic [11:0] instr_unused;

    assign op_alu       = bus.instr[14:12];
    assign instr_unused = bus.instr[11:0];

    ctrl_decode u_dec (
        .opcode_i   (bus.instr[15:12]),
        .cls_o      (cls),
        .is_store_o (is_store)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.alu_control  = ALU_MOV;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = SRC_B_RT;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = PC_SRC_ALU;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = WB_ALU_RD;
        bus.halted       = 1'b0;
        bus.illegal      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.mem_read    = 1'b1;
                bus.alu_src_b   = SRC_B_ONE;
                bus.alu_control = ALU_ADD;
                bus.ir_write    = bus.mem_ready;
                bus.pc_write    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // PC + imm lands in ALUOut here so BRANCH can use it as the target.
                bus.alu_src_b   = SRC_B_IMM;
                bus.alu_control = ALU_ADD;
                unique case (cls)
                    CLS_R:    state_d = S_EXEC_R;
                    CLS_I:    state_d = S_EXEC_I;
                    CLS_MEM:  state_d = S_MEM_ADDR;
                    CLS_BR:   state_d = S_BRANCH;
                    CLS_JMP:  state_d = S_JUMP;
                    CLS_HALT: state_d = S_HALT;
                    default: begin
                        state_d     = S_FETCH;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = op_alu;
                state_d         = S_WB_R;
            end
            S_WB_R: begin
                bus.alu_control = op_alu;
                bus.reg_write   = 1'b1;
                bus.wb_sel      = WB_ALU_RD;
                state_d         = S_FETCH;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRC_B_IMM;
                bus.alu_control = ALU_ADD;
                if (state_q == S_EXEC_I) state_d = S_WB_I;
                else                     state_d = is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_WB_I: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = WB_ALU_RT;
                state_d       = S_FETCH;
            end
            S_MEM_RD: begin
                bus.mem_read     = 1'b1;
                bus.mem_addr_sel = 1'b1;
                if (bus.mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = WB_MEM_RT;
                state_d       = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write    = 1'b1;
                bus.mem_addr_sel = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_MOV;
                bus.pc_src      = PC_SRC_ALUOUT;
                bus.pc_write    = bus.alu_zero;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_SRC_IMM;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Strobes are suppressed for the whole reset cycle, whatever state we sit in.
        if (reset) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.reg_write = 1'b0;
            bus.illegal   = 1'b0;
            bus.halted    = 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed per-cycle checks of the sequencer's control outputs from hand-computed vectors.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_sequencer_if bus ();
    alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.mem_read, bus.mem_write,
                  bus.mem_addr_sel, bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                  bus.wb_sel, bus.halted, bus.illegal};

    function automatic logic [17:0] o(input logic [2:0] ctl, input logic sa, input logic [1:0] sb,
                                      input logic mrd, input logic mwr, input logic as,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] wb, input logic h,
                                      input logic il);
        return {ctl, sa, sb, mrd, mwr, as, irw, pcw, pcs, rw, wb, h, il};
    endfunction

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic        mr;
        logic        az;
        logic [17:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [17:0] ex);
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, obs, ex);
        end
    endtask

    // Entered at posedge+1; checks mid-cycle, then advances one clock.
    task automatic step(input string nm, input logic [15:0] ins, input logic mrv,
                        input logic azv, input logic [17:0] ex);
        bus.instr     = ins;
        bus.mem_ready = mrv;
        bus.alu_zero  = azv;
        #2;
        check(nm, ex);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic [15:0] ins, input logic mrv,
                       input logic azv, input logic [17:0] ex);
        vec_t v;
        v.name = nm; v.instr = ins; v.mr = mrv; v.az = azv; v.exp = ex;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] F1, F0, DEC, DECI, EXI, WBI, MRD, WBM, MWR, JMP, HLT, RST_F, RST_MRD, ZERO;
        //         ctl    sa  sb    mrd  mwr  as   irw  pcw  pcs   rw   wb    h    il
        F1      = o(3'd1, 0, 2'd2, 1,   0,   0,   1,   1,   2'd0, 0,   2'd0, 0,   0);
        F0      = o(3'd1, 0, 2'd2, 1,   0,   0,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        RST_F   = o(3'd1, 0, 2'd2, 0,   0,   0,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        DEC     = o(3'd1, 0, 2'd1, 0,   0,   0,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        DECI    = o(3'd1, 0, 2'd1, 0,   0,   0,   0,   0,   2'd0, 0,   2'd0, 0,   1);
        EXI     = o(3'd1, 1, 2'd1, 0,   0,   0,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        WBI     = o(3'd0, 0, 2'd0, 0,   0,   0,   0,   0,   2'd0, 1,   2'd1, 0,   0);
        MRD     = o(3'd0, 0, 2'd0, 1,   0,   1,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        RST_MRD = o(3'd0, 0, 2'd0, 0,   0,   1,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        WBM     = o(3'd0, 0, 2'd0, 0,   0,   0,   0,   0,   2'd0, 1,   2'd2, 0,   0);
        MWR     = o(3'd0, 0, 2'd0, 0,   1,   1,   0,   0,   2'd0, 0,   2'd0, 0,   0);
        JMP     = o(3'd0, 0, 2'd0, 0,   0,   0,   0,   1,   2'd2, 0,   2'd0, 0,   0);
        HLT     = o(3'd0, 0, 2'd0, 0,   0,   0,   0,   0,   2'd0, 0,   2'd0, 1,   0);
        ZERO    = 18'd0;

        // ADD
        add("add_fetch",  16'h1298, 1, 0, F1);
        add("add_decode", 16'h1298, 1, 0, DEC);
        add("add_exec",   16'h1298, 1, 0, o(3'd1, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0));
        add("add_wb",     16'h1298, 1, 0, o(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0));
        // AND
        add("and_fetch",  16'h2000, 1, 0, F1);
        add("and_decode", 16'h2000, 1, 0, DEC);
        add("and_exec",   16'h2000, 1, 0, o(3'd2, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0));
        add("and_wb",     16'h2000, 1, 0, o(3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0));
        // SRL
        add("srl_fetch",  16'h7000, 1, 0, F1);
        add("srl_decode", 16'h7000, 1, 0, DEC);
        add("srl_exec",   16'h7000, 1, 0, o(3'd7, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0));
        add("srl_wb",     16'h7000, 1, 0, o(3'd7, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0));
        // ADDI
        add("addi_fetch", 16'h8005, 1, 0, F1);
        add("addi_dec",   16'h8005, 1, 0, DEC);
        add("addi_exec",  16'h8005, 1, 0, EXI);
        add("addi_wb",    16'h8005, 1, 0, WBI);
        // SW with one stall cycle
        add("sw_fetch",   16'hA040, 1, 0, F1);
        add("sw_dec",     16'hA040, 1, 0, DEC);
        add("sw_addr",    16'hA040, 1, 0, EXI);
        add("sw_stall",   16'hA040, 0, 0, MWR);
        add("sw_done",    16'hA040, 1, 0, MWR);
        // BZ taken, then not taken
        add("bz1_fetch",  16'hB010, 1, 1, F1);
        add("bz1_dec",    16'hB010, 1, 1, DEC);
        add("bz1_branch", 16'hB010, 1, 1, o(3'd0, 1, 2'd0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 0, 0));
        add("bz0_fetch",  16'hB010, 1, 0, F1);
        add("bz0_dec",    16'hB010, 1, 0, DEC);
        add("bz0_branch", 16'hB010, 1, 0, o(3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0));
        // J
        add("j_fetch",    16'hC020, 1, 0, F1);
        add("j_dec",      16'hC020, 1, 0, DEC);
        add("j_jump",     16'hC020, 1, 0, JMP);
        // Illegal opcodes, with a fetch stall in between
        add("ill5_fetch", 16'h5000, 1, 0, F1);
        add("ill5_dec",   16'h5000, 1, 0, DECI);
        add("fetch_stl0", 16'hD000, 0, 0, F0);
        add("fetch_stl1", 16'hD000, 0, 0, F0);
        add("illD_fetch", 16'hD000, 1, 0, F1);
        add("illD_dec",   16'hD000, 1, 0, DECI);
        add("illE_fetch", 16'hE000, 1, 0, F1);
        add("illE_dec",   16'hE000, 1, 0, DECI);
        add("post_ill",   16'h1000, 0, 0, F0);

        bus.instr = 16'h1000; bus.mem_ready = 1'b1; bus.alu_zero = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        #2;
        check("reset_forced", RST_F);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i].name, vecs[i].instr, vecs[i].mr, vecs[i].az, vecs[i].exp);
        step("sync_fetch", 16'h9000, 1, 0, F1);

        // LW with three stalled read cycles
        step("lw_dec",    16'h9048, 1, 0, DEC);
        step("lw_addr",   16'h9048, 1, 0, EXI);
        step("lw_stall1", 16'h9048, 0, 0, MRD);
        step("lw_stall2", 16'h9048, 0, 0, MRD);
        step("lw_stall3", 16'h9048, 0, 0, MRD);
        step("lw_rdone",  16'h9048, 1, 0, MRD);
        step("lw_wb",     16'h9048, 1, 0, WBM);

        // Reset while stalled in MEM_RD
        step("rlw_fetch", 16'h9048, 1, 0, F1);
        step("rlw_dec",   16'h9048, 1, 0, DEC);
        step("rlw_addr",  16'h9048, 1, 0, EXI);
        step("rlw_stall", 16'h9048, 0, 0, MRD);
        reset = 1'b1;
        step("rlw_reset", 16'h9048, 0, 0, RST_MRD);
        reset = 1'b0;
        step("rlw_after", 16'h9048, 0, 0, F0);
        step("halt_fetch", 16'hF000, 1, 0, F1);

        // HALT sticks until reset
        step("halt_dec",  16'hF000, 1, 1, DEC);
        for (int k = 0; k < 20; k++) step($sformatf("halt_%0d", k), 16'hF000, 1, 1, HLT);
        reset = 1'b1;
        step("halt_reset", 16'hF000, 1, 1, ZERO);
        reset = 1'b0;
        step("halt_exit", 16'h1000, 1, 0, F1);
        step("halt_exit_dec", 16'h1000, 1, 0, DEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
